// File: rtl/serdes_tx_arbiter_pkg.sv
// Shared types and constants for the SERDES transmit arbiter.
package serdes_arb_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned STALL_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_PAD  = 2'd3
  } arb_state_e;

  localparam logic [7:0]        HDR_TAG  = 8'hA5;
  localparam logic [DATA_W-1:0] PAD_WORD = 16'h0000;

endpackage

// File: rtl/serdes_tx_arbiter_if.sv
// Requester-side and tx-side signals of the arbiter; master drives requests, slave is the arbiter.
interface serdes_tx_arbiter_if #(
  parameter int unsigned NUM_CHAN = 4,
  parameter int unsigned CHAN_W   = 2
);
  import serdes_arb_pkg::*;

  logic [DATA_W*NUM_CHAN-1:0] req_dat_i;
  logic [NUM_CHAN-1:0]        req_valid_i;
  logic [NUM_CHAN-1:0]        req_sof_i;
  logic [NUM_CHAN-1:0]        req_eof_i;
  logic [NUM_CHAN-1:0]        req_rdy_o;
  logic [DATA_W-1:0]          tx_dat_o;
  logic                       tx_klsb_o;
  logic                       tx_kmsb_o;
  logic                       tx_en_o;
  logic                       tx_rdy_i;
  logic [CHAN_W-1:0]          cur_chan_o;
  logic                       busy_o;
  logic                       drop_o;
  logic                       abort_o;

  modport master (
    output req_dat_i, req_valid_i, req_sof_i, req_eof_i, tx_rdy_i,
    input  req_rdy_o, tx_dat_o, tx_klsb_o, tx_kmsb_o, tx_en_o,
           cur_chan_o, busy_o, drop_o, abort_o
  );

  modport slave (
    input  req_dat_i, req_valid_i, req_sof_i, req_eof_i, tx_rdy_i,
    output req_rdy_o, tx_dat_o, tx_klsb_o, tx_kmsb_o, tx_en_o,
           cur_chan_o, busy_o, drop_o, abort_o
  );

endinterface

// File: rtl/serdes_tx_arbiter_rr_pick.sv
// Round-robin picker: first requester after 'last', wrapping; combinational.
module rr_pick #(
  parameter int unsigned NUM_CHAN = 4,
  parameter int unsigned CHAN_W   = $clog2(NUM_CHAN)
) (
  input  logic [NUM_CHAN-1:0] req,
  input  logic [CHAN_W-1:0]   last,
  output logic [NUM_CHAN-1:0] gnt,
  output logic [CHAN_W-1:0]   idx
);

  logic [CHAN_W-1:0] cidx;
  logic              found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cidx  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CHAN; i++) begin
      cidx = CHAN_W'((32'(last) + i) % NUM_CHAN);
      if (!found && req[cidx]) begin
        gnt[cidx] = 1'b1;
        idx       = cidx;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serdes_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one SERDES tx input; bursts are padded to even length.
module serdes_tx_arbiter #(
  parameter int unsigned NUM_CHAN    = 4,
  parameter int unsigned CHAN_W      = $clog2(NUM_CHAN),
  parameter int unsigned STALL_LIMIT = 255,
  parameter logic [7:0]  HDR_TAG     = serdes_arb_pkg::HDR_TAG
) (
  input logic          dsp_clk,
  input logic          dsp_rst,
  serdes_tx_arbiter_if.slave bus
);
  import serdes_arb_pkg::*;

  arb_state_e           state_q, state_d;
  logic [CHAN_W-1:0]    cur_chan_q, cur_chan_d;
  logic [CHAN_W-1:0]    rr_last_q, rr_last_d;
  logic                 parity_q, parity_d;
  logic [STALL_W-1:0]   stall_q, stall_d;

  logic [NUM_CHAN-1:0]  elig, flush, pick_gnt;
  logic [CHAN_W-1:0]    pick_idx;
  logic                 pick_ok;
  logic [DATA_W-1:0]    chan_dat [NUM_CHAN];
  logic [DATA_W-1:0]    g_dat;
  logic                 g_valid, g_eof, accept, stall_hit;

  logic [NUM_CHAN-1:0]  req_rdy_c;
  logic [DATA_W-1:0]    tx_dat_c;
  logic                 tx_en_c, drop_c, abort_c;

  // Heads of packets compete; stray mid-packet words are flushed instead.
  assign elig  = bus.req_valid_i & bus.req_sof_i;
  assign flush = bus.req_valid_i & ~bus.req_sof_i;

  rr_pick #(.NUM_CHAN(NUM_CHAN), .CHAN_W(CHAN_W)) u_pick (
    .req  (elig),
    .last (rr_last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign pick_ok = |(pick_gnt & ~flush);

  always_comb begin
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      chan_dat[c] = bus.req_dat_i[c*DATA_W +: DATA_W];
    end
  end

  assign g_dat     = chan_dat[cur_chan_q];
  assign g_valid   = bus.req_valid_i[cur_chan_q];
  assign g_eof     = bus.req_eof_i[cur_chan_q];
  assign accept    = (state_q == ST_DATA) && g_valid && bus.tx_rdy_i;
  assign stall_hit = (state_q == ST_DATA) && !g_valid && bus.tx_rdy_i &&
                     (stall_q == STALL_W'(STALL_LIMIT));

  // State register and per-grant context.
  always_ff @(posedge dsp_clk or posedge dsp_rst) begin
    if (dsp_rst) begin
      state_q    <= ST_IDLE;
      cur_chan_q <= '0;
      rr_last_q  <= CHAN_W'(NUM_CHAN - 1);
      parity_q   <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_chan_q <= cur_chan_d;
      rr_last_q  <= rr_last_d;
      parity_q   <= parity_d;
      stall_q    <= stall_d;
    end
  end

  // Next state; tx_rdy_i low freezes everything including the stall count.
  always_comb begin
    state_d    = state_q;
    cur_chan_d = cur_chan_q;
    rr_last_d  = rr_last_q;
    parity_d   = parity_q;
    stall_d    = stall_q;
    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (bus.tx_rdy_i && pick_ok) begin
          state_d    = ST_HDR;
          cur_chan_d = pick_idx;
          rr_last_d  = pick_idx;
        end
      end
      ST_HDR: begin
        if (bus.tx_rdy_i) begin
          parity_d = 1'b1;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          parity_d = ~parity_q;
          stall_d  = '0;
          if (g_eof) state_d = (~parity_q) ? ST_PAD : ST_IDLE;
        end else if (stall_hit) begin
          stall_d = '0;
          state_d = parity_q ? ST_PAD : ST_IDLE;
        end else if (bus.tx_rdy_i) begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      ST_PAD: begin
        if (bus.tx_rdy_i) begin
          parity_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; flushing is suppressed while reset is held so all outputs read 0.
  always_comb begin
    req_rdy_c = '0;
    tx_dat_c  = '0;
    tx_en_c   = 1'b0;
    drop_c    = 1'b0;
    abort_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!dsp_rst && bus.tx_rdy_i) begin
          req_rdy_c = flush;
          drop_c    = |flush;
        end
      end
      ST_HDR: begin
        tx_dat_c = {HDR_TAG, 4'h0, 4'(cur_chan_q)};
        tx_en_c  = bus.tx_rdy_i;
      end
      ST_DATA: begin
        tx_dat_c              = g_dat;
        tx_en_c               = accept;
        req_rdy_c[cur_chan_q] = accept;
        abort_c               = stall_hit;
      end
      ST_PAD: begin
        tx_dat_c = PAD_WORD;
        tx_en_c  = bus.tx_rdy_i;
      end
      default: ;
    endcase
  end

  assign bus.req_rdy_o  = req_rdy_c;
  assign bus.tx_dat_o   = tx_dat_c;
  assign bus.tx_en_o    = tx_en_c;
  assign bus.tx_klsb_o  = 1'b0;
  assign bus.tx_kmsb_o  = 1'b0;
  assign bus.cur_chan_o = cur_chan_q;
  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.drop_o     = drop_c;
  assign bus.abort_o    = abort_c;

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// Self-checking bench for serdes_tx_arbiter: vector table, corner sequences, randomized stream check.
module tb_serdes_tx_arbiter;

  localparam int unsigned NUM_CHAN    = 4;
  localparam int unsigned CHAN_W      = 2;
  localparam int unsigned STALL_LIMIT = 4;

  logic dsp_clk = 1'b0;
  logic dsp_rst;
  always #5 dsp_clk = ~dsp_clk;

  serdes_tx_arbiter_if #(.NUM_CHAN(NUM_CHAN), .CHAN_W(CHAN_W)) bus ();

  serdes_tx_arbiter #(
    .NUM_CHAN(NUM_CHAN), .CHAN_W(CHAN_W), .STALL_LIMIT(STALL_LIMIT), .HDR_TAG(8'hA5)
  ) dut (
    .dsp_clk(dsp_clk), .dsp_rst(dsp_rst), .bus(bus)
  );

  typedef struct {
    int          ch;
    logic        v, s, e;
    logic [15:0] d;
    logic        rdy;
    logic        en;
    logic [15:0] edat;
    logic [3:0]  erdy;
    logic        busy;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eof;
  } word_t;

  vec_t  tbl[$];
  word_t src_q [NUM_CHAN][$];
  word_t exp_q [NUM_CHAN][$];
  bit    gap_ok [NUM_CHAN];

  int checks = 0;
  int errors = 0;
  int p_state, p_chan, p_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int ch, input logic v, input logic s, input logic e,
                              input logic [15:0] d, input logic rdy, input logic en,
                              input logic [15:0] edat, input logic [3:0] erdy, input logic busy);
    vec_t r;
    r.ch = ch; r.v = v; r.s = s; r.e = e; r.d = d; r.rdy = rdy;
    r.en = en; r.edat = edat; r.erdy = erdy; r.busy = busy;
    return r;
  endfunction

  task automatic set_ch(input int c, input logic v, input logic s, input logic e, input logic [15:0] d);
    bus.req_valid_i[CHAN_W'(c)] = v;
    bus.req_sof_i[CHAN_W'(c)]   = s;
    bus.req_eof_i[CHAN_W'(c)]   = e;
    bus.req_dat_i[6'(16*c) +: 16] = d;
  endtask

  task automatic clear_in();
    bus.req_valid_i = '0;
    bus.req_sof_i   = '0;
    bus.req_eof_i   = '0;
    bus.req_dat_i   = '0;
    bus.tx_rdy_i    = 1'b1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, ".en"},    32'(bus.tx_en_o), 0);
    chk({pfx, ".dat"},   32'(bus.tx_dat_o), 0);
    chk({pfx, ".rdy"},   32'(bus.req_rdy_o), 0);
    chk({pfx, ".busy"},  32'(bus.busy_o), 0);
    chk({pfx, ".drop"},  32'(bus.drop_o), 0);
    chk({pfx, ".abort"}, 32'(bus.abort_o), 0);
    chk({pfx, ".chan"},  32'(bus.cur_chan_o), 0);
    chk({pfx, ".k"},     32'({bus.tx_kmsb_o, bus.tx_klsb_o}), 0);
  endtask

  task automatic step(input logic rdy);
    @(posedge dsp_clk); #1;
    bus.tx_rdy_i = rdy;
  endtask

  // Stream parser: header names the channel, words must match that channel's next packet, pad if odd.
  task automatic parse_word(input logic [15:0] w);
    word_t x;
    case (p_state)
      0: begin
        chk("rnd.hdr", 32'(w[15:4]), 32'h00A50);
        p_chan = int'(w[1:0]);
        p_cnt  = 1;
        p_state = 1;
      end
      1: begin
        if (exp_q[p_chan].size() == 0) begin
          chk("rnd.extra_word", 1, 0);
          p_state = 0;
        end else begin
          x = exp_q[p_chan].pop_front();
          chk($sformatf("rnd.dat.ch%0d", p_chan), 32'(w), 32'(x.d));
          chk("rnd.chan", 32'(bus.cur_chan_o), 32'(p_chan));
          p_cnt++;
          if (x.eof) p_state = (p_cnt % 2 == 1) ? 2 : 0;
        end
      end
      default: begin
        chk("rnd.pad", 32'(w), 0);
        p_state = 0;
      end
    endcase
  endtask

  initial begin
    int len, cyc;
    bit done;
    int rpat [7] = '{1, 1, 0, 0, 0, 1, 1};

    clear_in();
    dsp_rst = 1'b1;
    repeat (2) @(posedge dsp_clk);
    #1;
    chk_zero("reset");
    @(posedge dsp_clk); #1;
    dsp_rst = 1'b0;

    // T1: ch0 A,B,C -> hdr + 3 words, no pad.
    tbl.push_back(mk(0, 1, 1, 0, 16'h1111, 1, 0, 16'h0000, 4'h0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h1111, 1, 1, 16'hA500, 4'h0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 16'h1111, 1, 1, 16'h1111, 4'h1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 16'h2222, 1, 1, 16'h2222, 4'h1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 16'h3333, 1, 1, 16'h3333, 4'h1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 4'h0, 0));
    // T2: ch1 D0,D1 -> hdr + 2 words + pad.
    tbl.push_back(mk(1, 1, 1, 0, 16'h4444, 1, 0, 16'h0000, 4'h0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 16'h4444, 1, 1, 16'hA501, 4'h0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 16'h4444, 1, 1, 16'h4444, 4'h2, 1));
    tbl.push_back(mk(1, 1, 0, 1, 16'h5555, 1, 1, 16'h5555, 4'h2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 4'h0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 4'h0, 0));
    // T4: ch2 with tx_rdy low for 5 cycles before its last word.
    tbl.push_back(mk(2, 1, 1, 0, 16'h6666, 1, 0, 16'h0000, 4'h0, 0));
    tbl.push_back(mk(2, 1, 1, 0, 16'h6666, 1, 1, 16'hA502, 4'h0, 1));
    tbl.push_back(mk(2, 1, 1, 0, 16'h6666, 1, 1, 16'h6666, 4'h4, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(2, 1, 0, 1, 16'h7777, 0, 0, 16'h7777, 4'h0, 1));
    tbl.push_back(mk(2, 1, 0, 1, 16'h7777, 1, 1, 16'h7777, 4'h4, 1));
    tbl.push_back(mk(2, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 4'h0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 4'h0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge dsp_clk); #1;
      clear_in();
      set_ch(tbl[i].ch, tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
      bus.tx_rdy_i = tbl[i].rdy;
      @(negedge dsp_clk);
      chk($sformatf("vec%0d.en", i),   32'(bus.tx_en_o),   32'(tbl[i].en));
      chk($sformatf("vec%0d.dat", i),  32'(bus.tx_dat_o),  32'(tbl[i].edat));
      chk($sformatf("vec%0d.rdy", i),  32'(bus.req_rdy_o), 32'(tbl[i].erdy));
      chk($sformatf("vec%0d.busy", i), 32'(bus.busy_o),    32'(tbl[i].busy));
    end

    // T5: ch2 stalls after hdr + 1 word; counter holds while tx_rdy low.
    step(1'b1); clear_in(); set_ch(2, 1, 1, 0, 16'h8888);
    @(negedge dsp_clk); chk("t5.idle.busy", 32'(bus.busy_o), 0);
    step(1'b1);
    @(negedge dsp_clk); chk("t5.hdr", 32'(bus.tx_dat_o), 32'hA502);
    step(1'b1);
    @(negedge dsp_clk); chk("t5.word.rdy", 32'(bus.req_rdy_o), 32'h4);
    for (int i = 0; i < 7; i++) begin
      step(rpat[i][0]); set_ch(2, 0, 0, 0, 16'h0000);
      @(negedge dsp_clk);
      chk($sformatf("t5.wait%0d.abort", i), 32'(bus.abort_o), 0);
      chk($sformatf("t5.wait%0d.busy", i), 32'(bus.busy_o), 1);
    end
    step(1'b1);
    @(negedge dsp_clk);
    chk("t5.abort", 32'(bus.abort_o), 1);
    chk("t5.abort.en", 32'(bus.tx_en_o), 0);
    step(1'b1); set_ch(2, 1, 0, 1, 16'h9999);
    @(negedge dsp_clk);
    chk("t5.nopad.busy", 32'(bus.busy_o), 0);
    chk("t5.drop", 32'(bus.drop_o), 1);
    chk("t5.drop.rdy", 32'(bus.req_rdy_o), 32'h4);
    chk("t5.drop.abort", 32'(bus.abort_o), 0);
    step(1'b1); clear_in();
    @(negedge dsp_clk); chk("t5.drop_end", 32'(bus.drop_o), 0);

    // T6: reset in mid-DATA of a ch1 packet.
    step(1'b1); set_ch(1, 1, 1, 0, 16'hAAAA);
    step(1'b1);
    @(negedge dsp_clk); chk("t6.hdr.chan", 32'(bus.cur_chan_o), 1);
    step(1'b1);
    @(negedge dsp_clk); chk("t6.word.rdy", 32'(bus.req_rdy_o), 32'h2);
    step(1'b1); set_ch(1, 1, 0, 0, 16'hBBBB);
    dsp_rst = 1'b1;
    #1;
    chk_zero("t6.rst");
    step(1'b1); dsp_rst = 1'b0; clear_in();

    // T3: all four 1-word packets; grant order 0..3 with a bubble each.
    for (int c = 0; c < 4; c++) set_ch(c, 1, 1, 1, 16'hC000 + 16'(c));
    for (int k = 0; k < 4; k++) begin
      @(negedge dsp_clk);
      chk($sformatf("t3.bubble%0d", k), 32'({bus.busy_o, bus.tx_en_o}), 0);
      step(1'b1);
      @(negedge dsp_clk);
      chk($sformatf("t3.hdr%0d", k), 32'(bus.tx_dat_o), 32'hA500 + k);
      chk($sformatf("t3.chan%0d", k), 32'(bus.cur_chan_o), k);
      step(1'b1);
      @(negedge dsp_clk);
      chk($sformatf("t3.dat%0d", k), 32'(bus.tx_dat_o), 32'hC000 + k);
      chk($sformatf("t3.rdy%0d", k), 32'(bus.req_rdy_o), 32'(1 << k));
      step(1'b1); set_ch(k, 0, 0, 0, 16'h0000);
    end
    @(negedge dsp_clk);
    chk("t3.end.busy", 32'(bus.busy_o), 0);

    // Random packets on all channels with random backpressure and short source gaps.
    for (int c = 0; c < NUM_CHAN; c++) begin
      gap_ok[c] = 1'b0;
      for (int p = 0; p < 6; p++) begin
        len = $urandom_range(1, 6);
        for (int w = 0; w < len; w++) begin
          word_t x;
          x.d = 16'($urandom);
          x.sof = (w == 0);
          x.eof = (w == len - 1);
          src_q[c].push_back(x);
          exp_q[c].push_back(x);
        end
      end
    end
    p_state = 0; p_chan = 0; p_cnt = 0;
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 5000) begin
      step(1'b1);
      bus.tx_rdy_i = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (src_q[c].size() > 0 && !(gap_ok[c] && $urandom_range(0, 3) == 0))
          set_ch(c, 1, src_q[c][0].sof, src_q[c][0].eof, src_q[c][0].d);
        else
          set_ch(c, 0, 0, 0, 16'h0000);
        gap_ok[c] = 1'b0;
      end
      @(negedge dsp_clk);
      chk("rnd.en_wo_rdy", 32'(bus.tx_en_o & ~bus.tx_rdy_i), 0);
      chk("rnd.rdy_wo_valid", 32'(bus.req_rdy_o & ~bus.req_valid_i), 0);
      chk("rnd.drop", 32'(bus.drop_o), 0);
      chk("rnd.abort", 32'(bus.abort_o), 0);
      if (bus.tx_en_o) parse_word(bus.tx_dat_o);
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (bus.req_rdy_o[CHAN_W'(c)]) begin
          if (src_q[c].size() > 0) void'(src_q[c].pop_front());
          gap_ok[c] = 1'b1;
        end
      end
      done = (p_state == 0) && !bus.busy_o;
      for (int c = 0; c < NUM_CHAN; c++) if (src_q[c].size() != 0) done = 1'b0;
      cyc++;
    end
    chk("rnd.timeout", 32'(done), 1);
    for (int c = 0; c < NUM_CHAN; c++)
      chk($sformatf("rnd.left.ch%0d", c), 32'(exp_q[c].size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
